bids22_round_seq: RTL and testbench

Round sequencer for the bids22 bidding DUV. On a single `go` pulse it walks the DUV's controller command port through a fixed configuration sequence: unlock, load X/Y/Z balances, set bid cost, set mask, set timer, lock, start round. It then waits for round completion and reports done or fail with the failing step. It sits between the testbench/host stimulus and the DUV controller port, replacing hand-driven command traffic.

---
 rtl/bids22_seq_pkg.sv | 45 ++++
 rtl/bids22_cmd_issuer.sv | 58 +++++
 rtl/bids22_round_seq.sv | 170 +++++++++++++++++
 tb/tb_bids22_round_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bids22_seq_pkg.sv
// Shared types for the bids22 round sequencer: controller opcodes, FSM states
// and the fixed step-to-opcode configuration table.
package bids22_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_UNLOCK    = 4'd1,
    OP_LOAD_X    = 4'd2,
    OP_LOAD_Y    = 4'd3,
    OP_LOAD_Z    = 4'd4,
    OP_SET_COST  = 4'd5,
    OP_SET_MASK  = 4'd6,
    OP_SET_TIMER = 4'd7,
    OP_LOCK      = 4'd8,
    OP_START     = 4'd9
  } c_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CHECK,
    S_WAIT_RO,
    S_DONE,
    S_FAIL
  } seq_state_t;

  localparam logic [3:0] FAIL_ABORT = 4'hF;
  localparam logic [3:0] LAST_STEP  = 4'd8;

  function automatic c_op_t step_op(input logic [3:0] step);
    case (step)
      4'd0:    step_op = OP_UNLOCK;
      4'd1:    step_op = OP_LOAD_X;
      4'd2:    step_op = OP_LOAD_Y;
      4'd3:    step_op = OP_LOAD_Z;
      4'd4:    step_op = OP_SET_COST;
      4'd5:    step_op = OP_SET_MASK;
      4'd6:    step_op = OP_SET_TIMER;
      4'd7:    step_op = OP_LOCK;
      4'd8:    step_op = OP_START;
      default: step_op = OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/bids22_cmd_issuer.sv
// Single-command handshake: holds C_start with a registered opcode/operand
// until the DUV accepts it, or flags a timeout after TIMEOUT idle cycles.
module bids22_cmd_issuer
  import bids22_seq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              launch,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] data,
  input  logic              kill,
  input  logic              ready,
  output logic              c_start,
  output logic [OP_W-1:0]   c_op,
  output logic [DATA_W-1:0] c_data,
  output logic              accepted,
  output logic              timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;

  assign accepted = c_start & ready;
  assign timeout  = c_start & ~ready & (wait_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_start  <= 1'b0;
      c_op     <= OP_W'(OP_NOP);
      c_data   <= '0;
      wait_cnt <= '0;
    end else if (kill) begin
      c_start  <= 1'b0;
      c_op     <= OP_W'(OP_NOP);
      c_data   <= '0;
      wait_cnt <= '0;
    end else if (launch) begin
      c_start  <= 1'b1;
      c_op     <= op;
      c_data   <= data;
      wait_cnt <= '0;
    end else if (accepted || timeout) begin
      c_start  <= 1'b0;
      c_op     <= OP_W'(OP_NOP);
      c_data   <= '0;
      wait_cnt <= '0;
    end else if (c_start) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bids22_round_seq.sv
// Round sequencer: on go, walks the DUV controller through unlock/load/config/
// lock/start, then waits for roundOver and reports done or fail.
module bids22_round_seq
  import bids22_seq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic              abort,
  input  logic [15:0]       key,
  input  logic [DATA_W-1:0] x_init,
  input  logic [DATA_W-1:0] y_init,
  input  logic [DATA_W-1:0] z_init,
  input  logic [DATA_W-1:0] bid_cost,
  input  logic [2:0]        mask,
  input  logic [DATA_W-1:0] round_timer,
  input  logic              ready,
  input  logic              err,
  input  logic              roundOver,
  output logic              C_start,
  output logic [OP_W-1:0]   C_op,
  output logic [DATA_W-1:0] C_data,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [3:0]        fail_step
);

  seq_state_t        state;
  logic [3:0]        step;
  logic [3:0]        nxt_step;
  logic              launch;
  logic              kill;
  logic [OP_W-1:0]   launch_op;
  logic [DATA_W-1:0] launch_data;
  logic              accepted;
  logic              timeout;

  logic [15:0]       key_s;
  logic [DATA_W-1:0] x_s, y_s, z_s, cost_s, timer_s;
  logic [2:0]        mask_s;

  // Snapshot of the configuration taken on the accepted go
  always_ff @(posedge clk) begin
    if (state == S_IDLE && go) begin
      key_s   <= key;
      x_s     <= x_init;
      y_s     <= y_init;
      z_s     <= z_init;
      cost_s  <= bid_cost;
      mask_s  <= mask;
      timer_s <= round_timer;
    end
  end

  assign kill = abort && (state != S_IDLE);

  // The first command leaves on the go edge, so it takes key straight from the port
  always_comb begin
    launch      = 1'b0;
    nxt_step    = step + 4'd1;
    launch_data = '0;
    if (state == S_IDLE) begin
      launch   = go;
      nxt_step = 4'd0;
    end else if (state == S_CHECK && !abort && !err && step != LAST_STEP) begin
      launch = 1'b1;
    end
    case (nxt_step)
      4'd0:    launch_data = DATA_W'(key);
      4'd1:    launch_data = x_s;
      4'd2:    launch_data = y_s;
      4'd3:    launch_data = z_s;
      4'd4:    launch_data = cost_s;
      4'd5:    launch_data = DATA_W'(mask_s);
      4'd6:    launch_data = timer_s;
      4'd7:    launch_data = DATA_W'(key_s);
      default: launch_data = '0;
    endcase
  end

  assign launch_op = OP_W'(step_op(nxt_step));

  bids22_cmd_issuer #(
    .DATA_W  (DATA_W),
    .OP_W    (OP_W),
    .TIMEOUT (TIMEOUT)
  ) u_issuer (
    .clk      (clk),
    .reset_n  (reset_n),
    .launch   (launch),
    .op       (launch_op),
    .data     (launch_data),
    .kill     (kill),
    .ready    (ready),
    .c_start  (C_start),
    .c_op     (C_op),
    .c_data   (C_data),
    .accepted (accepted),
    .timeout  (timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      step      <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_step <= 4'd0;
    end else if (kill) begin
      state     <= S_FAIL;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b1;
      fail_step <= FAIL_ABORT;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            state     <= S_ISSUE;
            step      <= 4'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_step <= 4'd0;
          end
        end
        S_ISSUE: begin
          if (accepted) begin
            state <= S_CHECK;
          end else if (timeout) begin
            state     <= S_FAIL;
            busy      <= 1'b0;
            fail      <= 1'b1;
            fail_step <= FAIL_ABORT;
          end
        end
        S_CHECK: begin
          if (err) begin
            state     <= S_FAIL;
            busy      <= 1'b0;
            fail      <= 1'b1;
            fail_step <= step;
          end else if (step == LAST_STEP) begin
            state <= S_WAIT_RO;
          end else begin
            state <= S_ISSUE;
            step  <= nxt_step;
          end
        end
        S_WAIT_RO: begin
          if (roundOver) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_FAIL:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bids22_round_seq.sv
// Directed bench for bids22_round_seq: nominal run, backpressure, command
// error, timeout, abort with go-while-busy, and reset mid-sequence.
module tb_bids22_round_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go, abort, ready, err, roundOver;
  logic [15:0] key;
  logic [31:0] x_init, y_init, z_init, bid_cost, round_timer;
  logic [2:0]  mask;
  logic        C_start;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        busy, done, fail;
  logic [3:0]  fail_step;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_data [9];

  always #5 clk = ~clk;

  bids22_round_seq #(.DATA_W(32), .OP_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .abort(abort), .key(key),
    .x_init(x_init), .y_init(y_init), .z_init(z_init), .bid_cost(bid_cost),
    .mask(mask), .round_timer(round_timer), .ready(ready), .err(err),
    .roundOver(roundOver), .C_start(C_start), .C_op(C_op), .C_data(C_data),
    .busy(busy), .done(done), .fail(fail), .fail_step(fail_step)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_cfg();
    key = 16'hA5A5; x_init = 32'd100; y_init = 32'd200; z_init = 32'd300;
    bid_cost = 32'd7; mask = 3'b101; round_timer = 32'd50;
  endtask

  initial begin
    exp_data[0] = 32'h0000A5A5; exp_data[1] = 32'd100; exp_data[2] = 32'd200;
    exp_data[3] = 32'd300;      exp_data[4] = 32'd7;   exp_data[5] = 32'd5;
    exp_data[6] = 32'd50;       exp_data[7] = 32'h0000A5A5; exp_data[8] = 32'd0;

    reset_n = 1'b0; go = 0; abort = 0; ready = 1; err = 0; roundOver = 0;
    load_cfg();
    tick(); tick();
    chk("rst_cstart", {31'd0, C_start}, 32'd0);
    chk("rst_cop", {28'd0, C_op}, 32'd0);
    chk("rst_cdata", C_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fail", {31'd0, fail}, 32'd0);
    chk("rst_fstep", {28'd0, fail_step}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Nominal run; inputs scrambled after go must not leak into the sequence
    go = 1; tick(); go = 0;
    x_init = 32'd999; y_init = 32'd888; key = 16'h1234; mask = 3'b010;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("nom_cstart_%0d", k), {31'd0, C_start}, 32'd1);
      chk($sformatf("nom_cop_%0d", k), {28'd0, C_op}, k + 1);
      chk($sformatf("nom_cdata_%0d", k), C_data, exp_data[k]);
      chk($sformatf("nom_busy_%0d", k), {31'd0, busy}, 32'd1);
      tick();
      chk($sformatf("nom_chk_cstart_%0d", k), {31'd0, C_start}, 32'd0);
      chk($sformatf("nom_chk_cop_%0d", k), {28'd0, C_op}, 32'd0);
      tick();
    end
    repeat (17) tick();
    chk("nom_wait_busy", {31'd0, busy}, 32'd1);
    chk("nom_wait_done", {31'd0, done}, 32'd0);
    chk("nom_wait_cstart", {31'd0, C_start}, 32'd0);
    roundOver = 1; tick(); roundOver = 0;
    chk("nom_done", {31'd0, done}, 32'd1);
    chk("nom_busy_lo", {31'd0, busy}, 32'd0);
    chk("nom_fail", {31'd0, fail}, 32'd0);
    tick(); tick();
    chk("nom_done_hold", {31'd0, done}, 32'd1);
    chk("nom_idle_cstart", {31'd0, C_start}, 32'd0);

    // Backpressure on LOAD_Y
    load_cfg();
    go = 1; tick(); go = 0;
    chk("bp_done_clr", {31'd0, done}, 32'd0);
    repeat (4) tick();
    ready = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_cstart_%0d", i), {31'd0, C_start}, 32'd1);
      chk($sformatf("bp_hold_cop_%0d", i), {28'd0, C_op}, 32'd3);
      chk($sformatf("bp_hold_cdata_%0d", i), C_data, 32'd200);
      tick();
    end
    ready = 1;
    chk("bp_acc_cstart", {31'd0, C_start}, 32'd1);
    chk("bp_acc_cop", {28'd0, C_op}, 32'd3);
    tick();
    chk("bp_check_cstart", {31'd0, C_start}, 32'd0);
    repeat (13) tick();
    chk("bp_wait_busy", {31'd0, busy}, 32'd1);
    roundOver = 1; tick(); roundOver = 0;
    chk("bp_done", {31'd0, done}, 32'd1);
    chk("bp_fail", {31'd0, fail}, 32'd0);
    tick();

    // err ignored outside CHECK, honoured in CHECK of SET_COST
    go = 1; tick(); go = 0;
    err = 1; tick(); err = 0;
    chk("err_ignored_fail", {31'd0, fail}, 32'd0);
    chk("err_ignored_busy", {31'd0, busy}, 32'd1);
    repeat (7) tick();
    chk("err_setcost_op", {28'd0, C_op}, 32'd5);
    tick();
    err = 1; tick(); err = 0;
    chk("err_fail", {31'd0, fail}, 32'd1);
    chk("err_fstep", {28'd0, fail_step}, 32'd4);
    chk("err_busy", {31'd0, busy}, 32'd0);
    chk("err_cstart", {31'd0, C_start}, 32'd0);
    repeat (3) tick();
    chk("err_no_more_cstart", {31'd0, C_start}, 32'd0);
    chk("err_fail_hold", {31'd0, fail}, 32'd1);
    chk("err_fstep_hold", {28'd0, fail_step}, 32'd4);

    // Timeout at UNLOCK with TIMEOUT=8
    ready = 0;
    go = 1; tick(); go = 0;
    chk("to_cstart_rise", {31'd0, C_start}, 32'd1);
    chk("to_cop", {28'd0, C_op}, 32'd1);
    chk("to_fail_clr", {31'd0, fail}, 32'd0);
    repeat (7) tick();
    chk("to_still_waiting", {31'd0, C_start}, 32'd1);
    chk("to_no_fail_yet", {31'd0, fail}, 32'd0);
    tick();
    chk("to_fail", {31'd0, fail}, 32'd1);
    chk("to_fstep", {28'd0, fail_step}, 32'hF);
    chk("to_cstart", {31'd0, C_start}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);
    ready = 1;
    tick();

    // Abort in WAIT_RO, with a go while busy beforehand
    go = 1; tick(); go = 0;
    repeat (18) tick();
    chk("ab_wait_busy", {31'd0, busy}, 32'd1);
    go = 1; tick(); go = 0;
    chk("ab_go_busy_cstart", {31'd0, C_start}, 32'd0);
    chk("ab_go_busy_busy", {31'd0, busy}, 32'd1);
    abort = 1; tick(); abort = 0;
    chk("ab_fail", {31'd0, fail}, 32'd1);
    chk("ab_fstep", {28'd0, fail_step}, 32'hF);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    chk("ab_no_restart", {31'd0, C_start}, 32'd0);
    chk("ab_idle_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of LOAD_X
    go = 1; tick(); go = 0;
    tick(); tick();
    chk("rm_loadx_op", {28'd0, C_op}, 32'd2);
    chk("rm_loadx_cstart", {31'd0, C_start}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rm_cstart", {31'd0, C_start}, 32'd0);
    chk("rm_cop", {28'd0, C_op}, 32'd0);
    chk("rm_cdata", C_data, 32'd0);
    chk("rm_busy", {31'd0, busy}, 32'd0);
    chk("rm_fail", {31'd0, fail}, 32'd0);
    chk("rm_fstep", {28'd0, fail_step}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    go = 1; tick(); go = 0;
    chk("rm_restart_cstart", {31'd0, C_start}, 32'd1);
    chk("rm_restart_op", {28'd0, C_op}, 32'd1);
    chk("rm_restart_data", C_data, 32'h0000A5A5);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
